// File: rtl/ask_demodulator.sv
// ASK demodulator: counts rx_in transitions per fixed-length bit window.
// Windows with at least EDGE_MIN edges decode as carrier-on (1), otherwise 0.
// Frame layout: one start window (must be 1), WORD_BITS data windows sent
// LSB first, and one stop window (must be 0).
// Output semantics: word_valid and frame_err are single-cycle pulses with no
// back-pressure. word_out changes only in the cycle word_valid is high and
// holds its value until the next good frame.
module ask_demodulator #(
    parameter int BIT_CYCLES = 64,
    parameter int EDGE_MIN   = 8,
    parameter int WORD_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [1:0]           o_dbg_state
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int EW = $clog2(BIT_CYCLES + 1);
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [EW-1:0] EDGE_THR = EW'(EDGE_MIN);
    localparam logic [EW-1:0] EDGE_SAT = '1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [CW-1:0]        r_win_cnt;
    logic [EW-1:0]        r_edge_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [WORD_BITS-1:0] r_shift;
    logic [WORD_BITS-1:0] r_word;
    logic                 r_word_valid;
    logic                 r_frame_err;
    logic                 w_edge;
    logic                 w_win_last;
    logic [EW-1:0]        w_edge_total;
    logic                 w_bit_on;

    assign word_out    = r_word;
    assign word_valid  = r_word_valid;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Edge detect and the window's edge total including this cycle's edge.
    always_comb begin
        w_edge       = r_sync2 ^ r_prev;
        w_win_last   = (r_win_cnt == WIN_LAST);
        w_edge_total = r_edge_cnt;
        if (w_edge && (r_edge_cnt != EDGE_SAT)) begin
            w_edge_total = r_edge_cnt + EW'(1);
        end
        w_bit_on = (w_edge_total >= EDGE_THR);
    end

    // Next-state logic: all transitions out of framing states happen on the
    // last cycle of a window.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_edge) w_next_state = S_START;
            end
            S_START: begin
                if (w_win_last) w_next_state = w_bit_on ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                if (w_win_last && (r_bit_cnt == BIT_LAST)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_win_last) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Window/edge/bit counters, shift register and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == S_IDLE) begin
                // The detecting cycle is window cycle 0 and counts as edge 1.
                r_win_cnt  <= w_edge ? CW'(1) : '0;
                r_edge_cnt <= w_edge ? EW'(1) : '0;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
            end else begin
                if (w_win_last) begin
                    r_win_cnt  <= '0;
                    r_edge_cnt <= '0;
                end else begin
                    r_win_cnt  <= r_win_cnt + CW'(1);
                    r_edge_cnt <= w_edge_total;
                end
                if ((r_state == S_DATA) && w_win_last) begin
                    r_shift   <= {w_bit_on, r_shift[WORD_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
                if ((r_state == S_STOP) && w_win_last) begin
                    if (!w_bit_on) begin
                        r_word       <= r_shift;
                        r_word_valid <= 1'b1;
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ask_demodulator.sv
// Bench for ask_demodulator: builds rx_in sequences, predicts outputs from
// window edge counts, and compares every cycle.
module tb_ask_demodulator;
  localparam int B    = 64;
  localparam int EM   = 8;
  localparam int W    = 10;
  localparam int MAXN = 8192;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b0;
  logic [W-1:0] word_out;
  logic word_valid;
  logic frame_err;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ask_demodulator #(.BIT_CYCLES(B), .EDGE_MIN(EM), .WORD_BITS(W)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .word_out(word_out),
    .word_valid(word_valid),
    .frame_err(frame_err),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic x_q[$];
  logic cur;
  logic ed[MAXN];
  logic ev[MAXN];
  logic ee[MAXN];
  logic eb[MAXN];
  logic [W-1:0] wupd[MAXN];
  logic [W-1:0] ew[MAXN];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input int t, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d got %0h expected %0h", tag, t, obs, expv);
    end
  endtask

  // stimulus builders
  task automatic gen_idle(input int n);
    repeat (n) x_q.push_back(cur);
  endtask

  // One bit window: n toggles every 2 cycles starting at offset off.
  task automatic gen_window(input int n, input int off);
    for (int i = 0; i < B; i++) begin
      if (n > 0 && i >= off && ((i - off) % 2 == 0) && ((i - off) / 2 < n)) cur = ~cur;
      x_q.push_back(cur);
    end
  endtask

  task automatic gen_rand_window(input bit on);
    int n;
    if (on) n = $urandom_range(31, EM);
    else    n = $urandom_range(EM - 1, 0);
    gen_window(n, (n == 0) ? 0 : $urandom_range(B - 2 * n + 1, 0));
  endtask

  task automatic gen_frame(input logic [W-1:0] d, input bit stop_bad);
    gen_window($urandom_range(31, EM), 0);
    for (int k = 0; k < W; k++) gen_rand_window(d[k]);
    gen_rand_window(stop_bad);
  endtask

  task automatic gen_frame_directed(input logic [W-1:0] d, input bit stop_bad);
    gen_window(32, 0);
    for (int k = 0; k < W; k++) gen_window(d[k] ? 32 : 0, 0);
    gen_window(stop_bad ? 32 : 0, 0);
  endtask

  // reference model
  function automatic int win_edges(input int s, input int k, input int n);
    int c = 0;
    for (int j = 0; j < B; j++) begin
      int idx = s + k * B + j;
      if (idx < n && ed[idx]) c++;
    end
    return c;
  endfunction

  task automatic mark_busy(input int a, input int b, input int n);
    for (int i = a; i <= b && i < n; i++) eb[i] = 1'b1;
  endtask

  // Sample i is taken just after the clock that captured x[i]; an edge at
  // drive index s starts a frame whose windows cover indices s + k*B ...,
  // busy shows from sample s+2, pulses land one sample after the last
  // window ends, and the line is watched again one cycle later.
  task automatic build_model(input int n);
    logic p;
    int t;
    int s;
    int e;
    logic [W-1:0] d;
    logic [W-1:0] w;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      ed[i] = x_q[i] ^ p;
      p = x_q[i];
      ev[i] = 1'b0;
      ee[i] = 1'b0;
      eb[i] = 1'b0;
    end
    exp_q.delete();
    t = 0;
    while (t < n) begin
      if (!ed[t]) begin
        t++;
      end else begin
        s = t;
        if (win_edges(s, 0, n) < EM) begin
          mark_busy(s + 2, s + B, n);
          t = s + B + 1;
        end else begin
          for (int k = 1; k <= W; k++) d[k-1] = (win_edges(s, k, n) >= EM);
          e = s + (W + 2) * B;
          mark_busy(s + 2, e, n);
          if (e + 1 < n) begin
            if (win_edges(s, W + 1, n) < EM) begin
              ev[e+1] = 1'b1;
              wupd[e+1] = d;
              exp_q.push_back(d);
            end else begin
              ee[e+1] = 1'b1;
            end
          end
          t = e + 1;
        end
      end
    end
    w = '0;
    for (int i = 0; i < n; i++) begin
      if (ev[i]) w = wupd[i];
      ew[i] = w;
    end
  endtask

  // driver + scoreboard
  task automatic run_segment(input int n);
    logic [W-1:0] expw;
    build_model(n);
    for (int t = 0; t < n; t++) begin
      rx_in = x_q[t];
      @(posedge clk);
      #1;
      check("word_valid", t, 16'(word_valid), 16'(ev[t]));
      check("frame_err", t, 16'(frame_err), 16'(ee[t]));
      check("busy", t, 16'(busy), 16'(eb[t]));
      check("dbg_idle", t, 16'(dbg_state == 2'd0), 16'(!eb[t]));
      check("word_out", t, 16'(word_out), 16'(ew[t]));
      if (ev[t] && exp_q.size() > 0) begin
        expw = exp_q.pop_front();
        check("word_at_valid", t, 16'(word_out), 16'(expw));
      end
    end
  endtask

  task automatic do_reset(input int cycles, input bit chk);
    rst = 1'b1;
    rx_in = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    if (chk) begin
      check("rst_word_out", 0, 16'(word_out), 16'h0);
      check("rst_word_valid", 0, 16'(word_valid), 16'h0);
      check("rst_frame_err", 0, 16'(frame_err), 16'h0);
      check("rst_busy", 0, 16'(busy), 16'h0);
      check("rst_dbg_state", 0, 16'(dbg_state), 16'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int cut;
    do_reset(3, 1'b1);

    // Directed: stop error first (word stays 0), good 2A5, glitch,
    // 8/7 edge thresholds with edges reaching the window's last cycle,
    // then back-to-back 155 / 0AA.
    x_q.delete();
    cur = 1'b0;
    gen_idle(5);
    gen_frame_directed(10'h2A5, 1'b1);
    gen_idle(1);
    gen_frame_directed(10'h2A5, 1'b0);
    gen_idle(10);
    cur = ~cur;
    gen_idle(3);
    cur = ~cur;
    gen_idle(80);
    gen_window(32, 0);
    gen_window(8, B - 15);
    repeat (W - 1) gen_window(0, 0);
    gen_window(0, 0);
    gen_idle(3);
    gen_window(32, 0);
    gen_window(7, B - 13);
    repeat (W - 1) gen_window(0, 0);
    gen_window(0, 0);
    gen_idle(3);
    gen_frame_directed(10'h155, 1'b0);
    gen_idle(1);
    gen_frame_directed(10'h0AA, 1'b0);
    gen_idle(5);
    run_segment(x_q.size());

    // Random frames, random edge counts, bad stops and rejected starts.
    do_reset(1, 1'b1);
    x_q.delete();
    cur = 1'b0;
    gen_idle(3);
    repeat (8) begin
      if ($urandom_range(9, 0) < 2) gen_window($urandom_range(EM - 1, 1), 0);
      else gen_frame(W'($urandom), ($urandom_range(3, 0) == 0));
      gen_idle($urandom_range(20, 1));
    end
    gen_idle(5);
    run_segment(x_q.size());

    // Mid-frame reset during data bit 5, then a clean 3FF frame.
    do_reset(1, 1'b1);
    x_q.delete();
    cur = 1'b0;
    gen_idle(4);
    gen_frame(10'h2A5, 1'b0);
    gen_idle(2);
    cut = x_q.size() + 6 * B + 20;
    gen_frame(10'h155, 1'b0);
    run_segment(cut);
    check("abort_busy", cut, 16'(busy), 16'h1);
    do_reset(1, 1'b1);
    x_q.delete();
    cur = 1'b0;
    gen_idle(4);
    gen_frame(10'h3FF, 1'b0);
    gen_idle(5);
    run_segment(x_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
